// File: rtl/apb_requester.sv
// APB (AMBA 3) requester: turns a single-outstanding valid/ready command
// into SETUP/ACCESS transfers and returns a one-cycle response.
// Ports: pclk/preset (async, active-high); cmd_valid/cmd_ready/cmd_write/
// cmd_addr/cmd_wdata host command; rsp_valid/rsp_rdata/rsp_err response;
// psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr APB bus.
// Optional wait-state timeout: define APB_REQ_TIMEOUT_EN.
module apb_requester #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int RD_LAG         = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, LAG
  } state_t;

  state_t state, state_nx;
  logic   accept;
  logic   fin;
  logic   tmo;
  logic   err_q;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wcnt;
  logic          wlim;

  // Reaching the limit means this edge is the TIMEOUT_CYCLES-th wait.
  assign wlim = (wcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wcnt <= '0;
    end else if (state == SETUP) begin
      wcnt <= '0;
    end else if (state == ACCESS && !pready) begin
      wcnt <= wcnt + CW'(1);
    end
  end
`else
  logic wlim;
  logic unused_cfg;
  assign wlim       = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fin      = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept   = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (!pwrite && RD_LAG != 0) begin
            state_nx = LAG;
          end else begin
            fin      = 1'b1;
            state_nx = IDLE;
          end
        end else if (wlim) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end
      end
      LAG: begin
        fin      = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_ready <= (state_nx == IDLE);
      psel      <= (state_nx == SETUP) ||
                   (state_nx == ACCESS);
      penable   <= (state_nx == ACCESS);
      rsp_valid <= fin || tmo;
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      // Lagged reads park pslverr so rsp_err only moves with rsp_valid.
      if (state == ACCESS && pready) begin
        err_q <= pslverr;
      end
      if (fin && state == ACCESS) begin
        rsp_err   <= pslverr;
        rsp_rdata <= pwrite ? '0 : prdata;
      end
      if (fin && state == LAG) begin
        rsp_err   <= err_q;
        rsp_rdata <= prdata;
      end
      if (tmo) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester (RD_LAG=1) with a registered
// read-data APB slave model and a high-level memory reference model.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  localparam int TO = 16;

  int          nchk = 0;
  int          nfail = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd = '0;
  logic        last_err = 1'b0;

  logic [31:0] mem [16];
  logic [7:0]  wcnt;
  logic [7:0]  wait_cfg = 8'd0;
  logic        err_cfg = 1'b0;
  logic        hang = 1'b0;
  logic        junk = 1'b0;

  apb_requester #(
    .AW(32), .DW(32), .RD_LAG(1),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  function automatic logic [31:0] init_val(int i);
    return (i == 1) ? 32'h5A5A5555 : (32'hC0DE0000 | i);
  endfunction

  // Slave: pready after wait_cfg wait states; prdata registered
  // on the access edge; pslverr is noise outside the completing edge.
  assign pready  = !hang && (wcnt == wait_cfg);
  assign pslverr = (psel && penable && pready) ? err_cfg : junk;

  always @(posedge pclk) begin
    if (preset) begin
      prdata <= '0;
      wcnt   <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      if (psel && penable && !pready) wcnt <= wcnt + 8'd1;
      else wcnt <= '0;
      if (psel && penable && pready) begin
        if (pwrite) mem[paddr[5:2]] <= pwdata;
        else prdata <= mem[paddr[5:2]];
      end
    end
  end

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    last_rd  = '0;
    last_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      junk = 1'($urandom);
      nchk++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 ||
          psel !== 1'b0 || rsp_rdata !== last_rd ||
          rsp_err !== last_err) begin
        nfail++;
        $display("FAIL idle: rv=%b rdy=%b sel=%b rd=%h err=%b want rd=%h err=%b",
                 rsp_valid, cmd_ready, psel, rsp_rdata, rsp_err,
                 last_rd, last_err);
      end
    end
  endtask

  // Issues one command from an IDLE cycle and returns in its rsp cycle.
  task automatic xfer(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input int waits,
                      input bit e, input bit to);
    int          cyc, npen, nsel, x_lat, x_pen;
    logic [31:0] x_rd;
    logic        x_err;
    x_rd  = (w || to) ? 32'h0 : ref_mem[a[5:2]];
    x_err = to ? 1'b1 : e;
    x_lat = to ? TO + 2 : (w ? 3 : 4) + waits;
    x_pen = to ? TO : waits + 1;
    wait_cfg = 8'(waits);
    err_cfg  = e;
    hang     = to;
    nchk++;
    if (cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL accept_ready: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(posedge pclk); #1;
    cyc = 1; npen = 0; nsel = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      if (psel) nsel++;
      if (penable) npen++;
      nchk++;
      if (cmd_ready !== 1'b0 ||
          (cyc == 1 && (psel !== 1'b1 || penable !== 1'b0)) ||
          (penable && !psel) ||
          (psel && (paddr !== a || pwrite !== w)) ||
          (psel && w && pwdata !== d) ||
          rsp_rdata !== last_rd || rsp_err !== last_err) begin
        nfail++;
        $display("FAIL bus_hold c%0d: rdy=%b sel=%b en=%b a=%h w=%b d=%h rd=%h want a=%h w=%b d=%h rd=%h",
                 cyc, cmd_ready, psel, penable, paddr, pwrite,
                 pwdata, rsp_rdata, a, w, d, last_rd);
      end
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      junk      = 1'($urandom);
      @(posedge pclk); #1;
      cyc++;
    end
    cmd_valid = 1'b0;
    hang      = 1'b0;
    nchk++;
    if (cyc !== x_lat || npen !== x_pen || nsel !== x_pen + 1) begin
      nfail++;
      $display("FAIL latency: lat=%0d pen=%0d sel=%0d want %0d %0d %0d",
               cyc, npen, nsel, x_lat, x_pen, x_pen + 1);
    end
    nchk++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== x_rd ||
        rsp_err !== x_err || cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL response %h: rv=%b rd=%h err=%b rdy=%b want rd=%h err=%b",
               a, rsp_valid, rsp_rdata, rsp_err, cmd_ready, x_rd, x_err);
    end
    last_rd  = x_rd;
    last_err = x_err;
    if (w && !to) ref_mem[a[5:2]] = d;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    ref_reset();
    repeat (2) @(posedge pclk);
    #1;
    nchk++;
    if (cmd_ready !== 1'b0 || psel !== 1'b0 || penable !== 1'b0 ||
        pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0 ||
        rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      nfail++;
      $display("FAIL reset_values: rdy=%b sel=%b en=%b pw=%b a=%h d=%h rv=%b rd=%h err=%b want all 0",
               cmd_ready, psel, penable, pwrite, paddr, pwdata,
               rsp_valid, rsp_rdata, rsp_err);
    end
    preset = 1'b0;
    idle(1);
  endtask

  task automatic test_write();
    xfer(1'b1, 32'h8, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_lagged_read();
    xfer(1'b0, 32'h4, 32'h0, 0, 1'b0, 1'b0);
    idle(1);
    xfer(1'b0, 32'h8, 32'h0, 0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_wait_states();
    xfer(1'b1, 32'h10, 32'h12345678, 3, 1'b0, 1'b0);
    idle(1);
    xfer(1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_slave_error();
    xfer(1'b1, 32'h14, 32'hA5A5F00D, 0, 1'b1, 1'b0);
    idle(1);
    xfer(1'b0, 32'h14, 32'h0, 1, 1'b0, 1'b0);
    idle(1);
    xfer(1'b0, 32'h18, 32'h0, 2, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    xfer(1'b1, 32'h20, 32'h0BADCAFE, 0, 1'b0, 1'b0);
    xfer(1'b0, 32'h20, 32'h0, 0, 1'b0, 1'b0);
    xfer(1'b1, 32'h24, 32'h600DF00D, 1, 1'b1, 1'b0);
    xfer(1'b0, 32'h24, 32'h0, 0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_access();
    int n;
    wait_cfg = 8'd3;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (penable !== 1'b1 && n < 10) begin
      @(posedge pclk); #1;
      n++;
    end
    #2;
    preset = 1'b1;
    #1;
    nchk++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 ||
        cmd_ready !== 1'b0 || n >= 10) begin
      nfail++;
      $display("FAIL reset_async: sel=%b en=%b rv=%b rdy=%b want 0 0 0 0",
               psel, penable, rsp_valid, cmd_ready);
    end
    ref_reset();
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    nchk++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
      nfail++;
      $display("FAIL reset_norsp: rv=%b rd=%h want 0 0", rsp_valid, rsp_rdata);
    end
    idle(2);
    xfer(1'b0, 32'h4, 32'h0, 0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_random();
    logic [3:0] idx;
    for (int i = 0; i < 40; i++) begin
      idx = 4'($urandom_range(0, 15));
      xfer(1'($urandom), {26'd0, idx, 2'b00}, $urandom,
           int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);
  endtask

`ifdef APB_REQ_TIMEOUT_EN
  task automatic test_timeout();
    xfer(1'b0, 32'h4, 32'h0, 0, 1'b0, 1'b1);
    idle(1);
    xfer(1'b1, 32'h28, 32'h11112222, 0, 1'b0, 1'b1);
    idle(1);
    xfer(1'b0, 32'h28, 32'h0, 2, 1'b0, 1'b0);
    idle(1);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_lagged_read();
    test_wait_states();
    test_slave_error();
    test_back_to_back();
    test_reset_access();
`ifdef APB_REQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB (AMBA 3) requester/initiator that drives the register slaves on the peripheral bus.
- Converts a single-outstanding valid/ready command interface from a host (testbench sequencer, CPU bridge or DMA) into compliant IDLE -> SETUP -> ACCESS bus transfers.
- Returns read data and error status on a one-cycle response pulse.
- Supports wait states (pready) and slaves that register prdata one cycle after the access edge.

Parameters:
AW, 32, paddr and cmd_addr width
DW, 32, pwdata/prdata/cmd_wdata/rsp_rdata width
RD_LAG, 1, 0 = sample prdata on the completing ACCESS edge; 1 = sample prdata one edge later (slaves that register read data on the access edge)
TIMEOUT_CYCLES, 16, wait-state limit; used only with APB_REQ_TIMEOUT_EN

Ports:
pclk  in  1  bus clock; all logic on rising edge
preset  in  1  asynchronous reset, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  requester can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  AW  transfer address
cmd_wdata  in  DW  write data
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  DW  read data (0 for writes)
rsp_err  out  1  pslverr (or timeout) of completed transfer
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  AW  APB address
pwdata  out  DW  APB write data
prdata  in  DW  APB read data
pready  in  1  slave ready; tie 1 for zero-wait slaves
pslverr  in  1  slave error; tie 0 if unsupported

Behaviour:
- All outputs are registered.
- Reset (preset=1, asynchronous):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err all go to 0.
  - cmd_ready is 0 while preset is asserted and 1 from the first edge after release.
- FSM states:
  - IDLE: cmd_ready=1, psel=0, penable=0. On cmd_valid&&cmd_ready, latch write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
  - SETUP: psel=1, penable=0, cmd_ready=0. Unconditionally go to ACCESS on the next edge.
  - ACCESS: psel=1, penable=1. Stay while pready=0. On an edge with pready=1:
    - If write, or read with RD_LAG=0: capture prdata (reads only; 0 for writes) and pslverr, pulse rsp_valid for the following cycle, go to IDLE.
    - If read with RD_LAG=1: capture pslverr, go to LAG.
  - LAG: psel=0, penable=0. On the next edge, capture prdata into rsp_rdata, pulse rsp_valid for the following cycle, go to IDLE.
- Timing:
  - Minimum transfer is 3 cycles (IDLE accept, SETUP, ACCESS).
  - Read with RD_LAG=1 takes 4 cycles.
  - rsp_valid rises the cycle cmd_ready returns to 1, so back-to-back commands are accepted with no bubble beyond IDLE.
- Bus signal stability:
  - paddr, pwdata and pwrite stay stable from SETUP through the end of ACCESS.
  - After completion they hold their last value (no toggling) until the next accept.
- cmd_* inputs are ignored when cmd_ready=0; only one transfer is outstanding.
- rsp_valid is high for exactly one cycle per accepted command. rsp_rdata and rsp_err hold until the next response.
- pslverr is sampled only on the completing edge (penable=1, pready=1); pslverr at other times is ignored.
- Reset mid-transfer:
  - psel and penable drop asynchronously.
  - No rsp_valid is issued for the aborted command.

Optional Feature:
- Macro: APB_REQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - On the edge where the count reaches TIMEOUT_CYCLES with pready still 0: go to IDLE, drop psel and penable, pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
  - A pready=1 on the same edge takes priority and completes normally.
- Not defined:
  - No counter is present and ACCESS waits indefinitely.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Write: cmd write addr 0x8 data 0xDEADBEEF, pready=1 -> psel rises in cycle 1; penable rises in cycle 2 with paddr=0x8, pwdata=0xDEADBEEF; rsp_valid=1, rsp_err=0 in cycle 3.
- Lagged read: RD_LAG=1, read 0x4 from a slave model that registers prdata on the access edge and holds reset value 0x5A5A5555 -> rsp_rdata=0x5A5A5555, rsp_valid one cycle after LAG. With RD_LAG=0 the same access returns the stale prdata (0x0).
- Wait states: pready=0 for 3 ACCESS cycles, then 1 -> penable stays high for 4 cycles with paddr stable; exactly one rsp_valid pulse.
- Slave error: pslverr=1 with pready on a write to 0x14 -> rsp_err=1. The next transfer returns rsp_err=0.
- Reset during ACCESS: assert preset while penable=1 -> psel and penable go to 0 immediately; no rsp_valid; after release cmd_ready=1 and a new read completes normally.
- Timeout (APB_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): pready held 0 -> after 16 wait cycles psel drops; rsp_valid=1, rsp_err=1, rsp_rdata=0.
